aes128_inv_cipher: RTL and testbench



---
 rtl/aes128_inv_cipher_pkg.sv | 123 ++++++++++++
 rtl/aes128_inv_cipher_round.sv | 46 ++++
 rtl/aes128_inv_cipher.sv | 125 ++++++++++++
 tb/tb_aes128_inv_cipher.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes128_inv_cipher_pkg.sv
// Shared AES-128 types, constants and byte/word helpers for the iterative inverse cipher.
package aes_pkg;

  localparam int         NK = 4;
  localparam logic [3:0] NR = 4'd10;

  typedef logic [3:0][3:0][7:0] state_t;

  typedef enum logic [1:0] {
    IDLE,
    KEXP,
    ROUND
  } fsm_t;

  // Index 1 sits in the low byte so RCON[i] matches the FIPS-197 round number.
  localparam logic [10:1][7:0] RCON = {8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
                                       8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] s;
    case (b)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] s;
    case (b)
      8'h00: s = 8'h52; 8'h01: s = 8'h09; 8'h02: s = 8'h6a; 8'h03: s = 8'hd5; 8'h04: s = 8'h30; 8'h05: s = 8'h36; 8'h06: s = 8'ha5; 8'h07: s = 8'h38;
      8'h08: s = 8'hbf; 8'h09: s = 8'h40; 8'h0a: s = 8'ha3; 8'h0b: s = 8'h9e; 8'h0c: s = 8'h81; 8'h0d: s = 8'hf3; 8'h0e: s = 8'hd7; 8'h0f: s = 8'hfb;
      8'h10: s = 8'h7c; 8'h11: s = 8'he3; 8'h12: s = 8'h39; 8'h13: s = 8'h82; 8'h14: s = 8'h9b; 8'h15: s = 8'h2f; 8'h16: s = 8'hff; 8'h17: s = 8'h87;
      8'h18: s = 8'h34; 8'h19: s = 8'h8e; 8'h1a: s = 8'h43; 8'h1b: s = 8'h44; 8'h1c: s = 8'hc4; 8'h1d: s = 8'hde; 8'h1e: s = 8'he9; 8'h1f: s = 8'hcb;
      8'h20: s = 8'h54; 8'h21: s = 8'h7b; 8'h22: s = 8'h94; 8'h23: s = 8'h32; 8'h24: s = 8'ha6; 8'h25: s = 8'hc2; 8'h26: s = 8'h23; 8'h27: s = 8'h3d;
      8'h28: s = 8'hee; 8'h29: s = 8'h4c; 8'h2a: s = 8'h95; 8'h2b: s = 8'h0b; 8'h2c: s = 8'h42; 8'h2d: s = 8'hfa; 8'h2e: s = 8'hc3; 8'h2f: s = 8'h4e;
      8'h30: s = 8'h08; 8'h31: s = 8'h2e; 8'h32: s = 8'ha1; 8'h33: s = 8'h66; 8'h34: s = 8'h28; 8'h35: s = 8'hd9; 8'h36: s = 8'h24; 8'h37: s = 8'hb2;
      8'h38: s = 8'h76; 8'h39: s = 8'h5b; 8'h3a: s = 8'ha2; 8'h3b: s = 8'h49; 8'h3c: s = 8'h6d; 8'h3d: s = 8'h8b; 8'h3e: s = 8'hd1; 8'h3f: s = 8'h25;
      8'h40: s = 8'h72; 8'h41: s = 8'hf8; 8'h42: s = 8'hf6; 8'h43: s = 8'h64; 8'h44: s = 8'h86; 8'h45: s = 8'h68; 8'h46: s = 8'h98; 8'h47: s = 8'h16;
      8'h48: s = 8'hd4; 8'h49: s = 8'ha4; 8'h4a: s = 8'h5c; 8'h4b: s = 8'hcc; 8'h4c: s = 8'h5d; 8'h4d: s = 8'h65; 8'h4e: s = 8'hb6; 8'h4f: s = 8'h92;
      8'h50: s = 8'h6c; 8'h51: s = 8'h70; 8'h52: s = 8'h48; 8'h53: s = 8'h50; 8'h54: s = 8'hfd; 8'h55: s = 8'hed; 8'h56: s = 8'hb9; 8'h57: s = 8'hda;
      8'h58: s = 8'h5e; 8'h59: s = 8'h15; 8'h5a: s = 8'h46; 8'h5b: s = 8'h57; 8'h5c: s = 8'ha7; 8'h5d: s = 8'h8d; 8'h5e: s = 8'h9d; 8'h5f: s = 8'h84;
      8'h60: s = 8'h90; 8'h61: s = 8'hd8; 8'h62: s = 8'hab; 8'h63: s = 8'h00; 8'h64: s = 8'h8c; 8'h65: s = 8'hbc; 8'h66: s = 8'hd3; 8'h67: s = 8'h0a;
      8'h68: s = 8'hf7; 8'h69: s = 8'he4; 8'h6a: s = 8'h58; 8'h6b: s = 8'h05; 8'h6c: s = 8'hb8; 8'h6d: s = 8'hb3; 8'h6e: s = 8'h45; 8'h6f: s = 8'h06;
      8'h70: s = 8'hd0; 8'h71: s = 8'h2c; 8'h72: s = 8'h1e; 8'h73: s = 8'h8f; 8'h74: s = 8'hca; 8'h75: s = 8'h3f; 8'h76: s = 8'h0f; 8'h77: s = 8'h02;
      8'h78: s = 8'hc1; 8'h79: s = 8'haf; 8'h7a: s = 8'hbd; 8'h7b: s = 8'h03; 8'h7c: s = 8'h01; 8'h7d: s = 8'h13; 8'h7e: s = 8'h8a; 8'h7f: s = 8'h6b;
      8'h80: s = 8'h3a; 8'h81: s = 8'h91; 8'h82: s = 8'h11; 8'h83: s = 8'h41; 8'h84: s = 8'h4f; 8'h85: s = 8'h67; 8'h86: s = 8'hdc; 8'h87: s = 8'hea;
      8'h88: s = 8'h97; 8'h89: s = 8'hf2; 8'h8a: s = 8'hcf; 8'h8b: s = 8'hce; 8'h8c: s = 8'hf0; 8'h8d: s = 8'hb4; 8'h8e: s = 8'he6; 8'h8f: s = 8'h73;
      8'h90: s = 8'h96; 8'h91: s = 8'hac; 8'h92: s = 8'h74; 8'h93: s = 8'h22; 8'h94: s = 8'he7; 8'h95: s = 8'had; 8'h96: s = 8'h35; 8'h97: s = 8'h85;
      8'h98: s = 8'he2; 8'h99: s = 8'hf9; 8'h9a: s = 8'h37; 8'h9b: s = 8'he8; 8'h9c: s = 8'h1c; 8'h9d: s = 8'h75; 8'h9e: s = 8'hdf; 8'h9f: s = 8'h6e;
      8'ha0: s = 8'h47; 8'ha1: s = 8'hf1; 8'ha2: s = 8'h1a; 8'ha3: s = 8'h71; 8'ha4: s = 8'h1d; 8'ha5: s = 8'h29; 8'ha6: s = 8'hc5; 8'ha7: s = 8'h89;
      8'ha8: s = 8'h6f; 8'ha9: s = 8'hb7; 8'haa: s = 8'h62; 8'hab: s = 8'h0e; 8'hac: s = 8'haa; 8'had: s = 8'h18; 8'hae: s = 8'hbe; 8'haf: s = 8'h1b;
      8'hb0: s = 8'hfc; 8'hb1: s = 8'h56; 8'hb2: s = 8'h3e; 8'hb3: s = 8'h4b; 8'hb4: s = 8'hc6; 8'hb5: s = 8'hd2; 8'hb6: s = 8'h79; 8'hb7: s = 8'h20;
      8'hb8: s = 8'h9a; 8'hb9: s = 8'hdb; 8'hba: s = 8'hc0; 8'hbb: s = 8'hfe; 8'hbc: s = 8'h78; 8'hbd: s = 8'hcd; 8'hbe: s = 8'h5a; 8'hbf: s = 8'hf4;
      8'hc0: s = 8'h1f; 8'hc1: s = 8'hdd; 8'hc2: s = 8'ha8; 8'hc3: s = 8'h33; 8'hc4: s = 8'h88; 8'hc5: s = 8'h07; 8'hc6: s = 8'hc7; 8'hc7: s = 8'h31;
      8'hc8: s = 8'hb1; 8'hc9: s = 8'h12; 8'hca: s = 8'h10; 8'hcb: s = 8'h59; 8'hcc: s = 8'h27; 8'hcd: s = 8'h80; 8'hce: s = 8'hec; 8'hcf: s = 8'h5f;
      8'hd0: s = 8'h60; 8'hd1: s = 8'h51; 8'hd2: s = 8'h7f; 8'hd3: s = 8'ha9; 8'hd4: s = 8'h19; 8'hd5: s = 8'hb5; 8'hd6: s = 8'h4a; 8'hd7: s = 8'h0d;
      8'hd8: s = 8'h2d; 8'hd9: s = 8'he5; 8'hda: s = 8'h7a; 8'hdb: s = 8'h9f; 8'hdc: s = 8'h93; 8'hdd: s = 8'hc9; 8'hde: s = 8'h9c; 8'hdf: s = 8'hef;
      8'he0: s = 8'ha0; 8'he1: s = 8'he0; 8'he2: s = 8'h3b; 8'he3: s = 8'h4d; 8'he4: s = 8'hae; 8'he5: s = 8'h2a; 8'he6: s = 8'hf5; 8'he7: s = 8'hb0;
      8'he8: s = 8'hc8; 8'he9: s = 8'heb; 8'hea: s = 8'hbb; 8'heb: s = 8'h3c; 8'hec: s = 8'h83; 8'hed: s = 8'h53; 8'hee: s = 8'h99; 8'hef: s = 8'h61;
      8'hf0: s = 8'h17; 8'hf1: s = 8'h2b; 8'hf2: s = 8'h04; 8'hf3: s = 8'h7e; 8'hf4: s = 8'hba; 8'hf5: s = 8'h77; 8'hf6: s = 8'hd6; 8'hf7: s = 8'h26;
      8'hf8: s = 8'he1; 8'hf9: s = 8'h69; 8'hfa: s = 8'h14; 8'hfb: s = 8'h63; 8'hfc: s = 8'h55; 8'hfd: s = 8'h21; 8'hfe: s = 8'h0c; 8'hff: s = 8'h7d;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes128_inv_cipher_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, and
// InvMixColumns unless this is the final round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] round_key,
  input  logic         last,
  output logic [127:0] state_o
);

  state_t     s_in;
  state_t     k_in;
  state_t     t;
  state_t     mc;
  logic [7:0] b0, b1, b2, b3;

  // Byte (row r, col c) lives at [3-c][3-r] because column 0 occupies the top word.
  always_comb begin
    s_in = state_i;
    k_in = round_key;
    t    = '0;
    mc   = '0;
    b0   = 8'h00;
    b1   = 8'h00;
    b2   = 8'h00;
    b3   = 8'h00;
    for (int c = 0; c < NK; c++) begin
      for (int r = 0; r < 4; r++) begin
        t[3-c][3-r] = inv_sbox(s_in[3 - ((c - r + 4) % 4)][3-r]) ^ k_in[3-c][3-r];
      end
    end
    for (int c = 0; c < NK; c++) begin
      b0 = t[3-c][3];
      b1 = t[3-c][2];
      b2 = t[3-c][1];
      b3 = t[3-c][0];
      mc[3-c][3] = gmul(b0, 8'h0e) ^ gmul(b1, 8'h0b) ^ gmul(b2, 8'h0d) ^ gmul(b3, 8'h09);
      mc[3-c][2] = gmul(b0, 8'h09) ^ gmul(b1, 8'h0e) ^ gmul(b2, 8'h0b) ^ gmul(b3, 8'h0d);
      mc[3-c][1] = gmul(b0, 8'h0d) ^ gmul(b1, 8'h09) ^ gmul(b2, 8'h0e) ^ gmul(b3, 8'h0b);
      mc[3-c][0] = gmul(b0, 8'h0b) ^ gmul(b1, 8'h0d) ^ gmul(b2, 8'h09) ^ gmul(b3, 8'h0e);
    end
    state_o = last ? t : mc;
  end

endmodule

// File: rtl/aes128_inv_cipher.sv
// Iterative AES-128 decryptor: ten forward key-expansion steps to reach the last round
// key, then ten inverse rounds that walk the key schedule backwards. 20-cycle latency.
module aes128_inv_cipher
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [127:0] key,
  input  logic [127:0] cipher,
  output logic [127:0] word,
  output logic         done,
  output logic         busy
);

  fsm_t         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [127:0] ct_q, ct_d;
  logic [127:0] word_q, word_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         done_q, done_d;
  logic         busy_q, busy_d;

  logic [3:0]   rnd_inc;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  f0, f1, f2, f3;
  logic [31:0]  i0, i1, i2, i3;
  logic [127:0] fwd_rk, inv_rk, round_out;

  // Inverse step undoes the forward chain from w3 down, so w0 needs the recovered w3.
  always_comb begin
    {w0, w1, w2, w3} = rk_q;
    rnd_inc = rnd_q + 4'd1;
    f0 = w0 ^ sub_word(rot_word(w3)) ^ {RCON[rnd_q], 24'h000000};
    f1 = w1 ^ f0;
    f2 = w2 ^ f1;
    f3 = w3 ^ f2;
    i3 = w3 ^ w2;
    i2 = w2 ^ w1;
    i1 = w1 ^ w0;
    i0 = w0 ^ sub_word(rot_word(i3)) ^ {RCON[rnd_inc], 24'h000000};
    fwd_rk = {f0, f1, f2, f3};
    inv_rk = {i0, i1, i2, i3};
  end

  aes_inv_round u_round (
    .state_i   (state_q),
    .round_key (inv_rk),
    .last      (rnd_q == 4'd0),
    .state_o   (round_out)
  );

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rk_d    = rk_q;
    ct_d    = ct_q;
    word_d  = word_q;
    rnd_d   = rnd_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    case (fsm_q)
      IDLE: begin
        if (en) begin
          rk_d   = key;
          ct_d   = cipher;
          rnd_d  = 4'd1;
          busy_d = 1'b1;
          fsm_d  = KEXP;
        end
      end
      KEXP: begin
        rk_d = fwd_rk;
        if (rnd_q == NR) begin
          state_d = ct_q ^ fwd_rk;
          rnd_d   = NR - 4'd1;
          fsm_d   = ROUND;
        end else begin
          rnd_d = rnd_inc;
        end
      end
      ROUND: begin
        if (rnd_q != 4'd0) begin
          state_d = round_out;
          rk_d    = inv_rk;
          rnd_d   = rnd_q - 4'd1;
        end else begin
          word_d = round_out;
          done_d = 1'b1;
          busy_d = 1'b0;
          fsm_d  = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rk_q    <= '0;
      ct_q    <= '0;
      word_q  <= '0;
      rnd_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rk_q    <= rk_d;
      ct_q    <= ct_d;
      word_q  <= word_d;
      rnd_q   <= rnd_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign word = word_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_aes128_inv_cipher.sv
// Bench for aes128_inv_cipher: FIPS-197 vectors, input stability, back-to-back, reset abort,
// and random blocks encrypted by an independent forward-cipher model.
module tb_aes128_inv_cipher;

  localparam logic [127:0] KEY_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] RK10_B  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [127:0] key;
  logic [127:0] cipher;
  logic [127:0] word;
  logic         done;
  logic         busy;

  int           n_vectors;
  int           n_miscompares;
  logic [7:0]   sb [256];

  aes128_inv_cipher dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .key    (key),
    .cipher (cipher),
    .word   (word),
    .done   (done),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
  task automatic buildSbox();
    logic [7:0] a;
    for (int x = 0; x < 256; x++) begin
      a = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gf_mul(8'(x), 8'(y)) == 8'h01) a = 8'(y);
      end
      sb[x] = a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] k, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] out;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h000000};
        rc  = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[4*(((i/4) + (i%4)) % 4) + (i%4)]];
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++) begin
          if (rd < 10)
            s[4*c+r] = gf_mul(t[4*c+r], 8'h02) ^ gf_mul(t[4*c+(r+1)%4], 8'h03)
                     ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
          else
            s[4*c+r] = t[4*c+r];
          s[4*c+r] = s[4*c+r] ^ w[4*rd+c][31-8*r -: 8];
        end
      end
    end
    out = '0;
    for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
    return out;
  endfunction

  task automatic randomPair(output logic [127:0] k, output logic [127:0] p, output logic [127:0] c);
    k = {$urandom, $urandom, $urandom, $urandom};
    p = {$urandom, $urandom, $urandom, $urandom};
    c = encrypt(k, p);
  endtask

  // Returns on the falling edge just after the accept edge.
  task automatic applyStimulus(input logic [127:0] k, input logic [127:0] c);
    @(negedge clk);
    en     = 1'b1;
    key    = k;
    cipher = c;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic waitDone(output int lat);
    lat = -1;
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int           lat;
    int           ndone;
    int           first_k;
    int           second_k;
    logic [127:0] w1, w2, k1, k2, p1, p2, c1, c2, kr, pr, cr;

    n_vectors     = 0;
    n_miscompares = 0;
    rst_n  = 1'b0;
    en     = 1'b0;
    key    = '0;
    cipher = '0;
    buildSbox();

    repeat (3) @(negedge clk);
    checkOutput("reset_word", word, 128'h0);
    checkOutput("reset_busy_done", {busy, done}, 2'b00);
    rst_n = 1'b1;

    applyStimulus(KEY_C1, CT_C1);
    checkOutput("c1_busy", busy, 1'b1);
    waitDone(lat);
    checkOutput("c1_latency", lat, 20);
    checkOutput("c1_word", word, PT_C1);
    checkOutput("c1_done_busy", {busy, done}, 2'b01);
    @(negedge clk);
    checkOutput("c1_pulse_end", {busy, done}, 2'b00);

    applyStimulus(KEY_B, CT_B);
    ndone   = 0;
    first_k = -1;
    w1      = '0;
    for (int kk = 0; kk <= 30; kk++) begin
      if (kk > 0) @(negedge clk);
      if (kk == 2) begin
        key    = '1;
        cipher = '1;
      end
      if (kk == 4) en = 1'b1;
      if (kk == 5) en = 1'b0;
      if (kk == 10) checkOutput("b_rk10", dut.rk_q, RK10_B);
      if (done) begin
        ndone++;
        if (first_k < 0) begin
          first_k = kk;
          w1      = word;
        end
      end
    end
    checkOutput("b_done_count", ndone, 1);
    checkOutput("b_latency", first_k, 20);
    checkOutput("b_word", w1, PT_B);

    randomPair(k1, p1, c1);
    randomPair(k2, p2, c2);
    @(negedge clk);
    en     = 1'b1;
    key    = k1;
    cipher = c1;
    @(posedge clk);
    ndone    = 0;
    first_k  = -1;
    second_k = -1;
    w1       = '0;
    w2       = '0;
    for (int kk = 0; kk <= 50; kk++) begin
      @(negedge clk);
      if (kk == 0) begin
        key    = k2;
        cipher = c2;
      end
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          first_k = kk;
          w1      = word;
        end else if (ndone == 2) begin
          second_k = kk;
          w2       = word;
          en       = 1'b0;
        end
      end
    end
    en = 1'b0;
    repeat (25) @(negedge clk);
    checkOutput("b2b_done_count", ndone, 2);
    checkOutput("b2b_first_at", first_k, 20);
    checkOutput("b2b_second_at", second_k, 41);
    checkOutput("b2b_first_word", w1, p1);
    checkOutput("b2b_second_word", w2, p2);

    applyStimulus(KEY_C1, CT_C1);
    ndone = 0;
    for (int kk = 0; kk <= 30; kk++) begin
      if (kk > 0) @(negedge clk);
      if (kk == 11) begin
        rst_n = 1'b0;
        #1;
        checkOutput("abort_word", word, 128'h0);
        checkOutput("abort_busy_done", {busy, done}, 2'b00);
      end
      if (kk == 12) rst_n = 1'b1;
      if (done) ndone++;
    end
    checkOutput("abort_no_done", ndone, 0);
    checkOutput("abort_word_held", word, 128'h0);

    applyStimulus(KEY_C1, CT_C1);
    waitDone(lat);
    checkOutput("c1_after_abort_latency", lat, 20);
    checkOutput("c1_after_abort_word", word, PT_C1);

    for (int n = 0; n < 1000; n++) begin
      randomPair(kr, pr, cr);
      applyStimulus(kr, cr);
      waitDone(lat);
      checkOutput("rand_latency", lat, 20);
      checkOutput("rand_word", word, pr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
